// File: rtl/gray_cnt_dual_p.sv
// Dual-width Gray counter: an N-bit Gray pointer plus an (N-1)-bit Gray address, both registered from one binary state.
// Optional saturating mode is selected by defining GRAY_CNT_SAT_EN.
module gray_cnt_dual_p #(
  parameter int unsigned N       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  output logic [N-1:0] n_gr_cnt,
  output logic [N-2:0] n_1_gr_cnt,
  output logic [N-1:0] bin_cnt,
  output logic         tc,
  output logic         wrap
);

  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RST_B  = RST_VAL[N-1:0];
  localparam logic [N-1:0] RST_G  = RST_B ^ (RST_B >> 1);
  localparam logic [N-2:0] RST_G1 = {RST_G[N-1] ^ RST_G[N-2], RST_G[N-3:0]};

  logic [N-1:0] b_nxt;
  logic [N-1:0] g_nxt;
  logic [N-2:0] g1_nxt;
  logic         wrap_nxt;
  logic         at_max;
  logic         at_min;

  assign at_max = (bin_cnt == '1);
  assign at_min = (bin_cnt == '0);
  assign tc     = up_dn ? at_max : at_min;

  always_comb begin
    b_nxt    = bin_cnt;
    wrap_nxt = 1'b0;
    if (ld) begin
      b_nxt = ld_val;
    end else if (en) begin
      if (up_dn) begin
`ifdef GRAY_CNT_SAT_EN
        if (!at_max) b_nxt = bin_cnt + ONE;
`else
        b_nxt    = bin_cnt + ONE;
        wrap_nxt = at_max;
`endif
      end else begin
`ifdef GRAY_CNT_SAT_EN
        if (!at_min) b_nxt = bin_cnt - ONE;
`else
        b_nxt    = bin_cnt - ONE;
        wrap_nxt = at_min;
`endif
      end
    end
  end

  // Narrow code folds the top two Gray bits, equal to gray(b_nxt[N-2:0]).
  assign g_nxt  = b_nxt ^ (b_nxt >> 1);
  assign g1_nxt = {g_nxt[N-1] ^ g_nxt[N-2], g_nxt[N-3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_cnt    <= RST_B;
      n_gr_cnt   <= RST_G;
      n_1_gr_cnt <= RST_G1;
      wrap       <= 1'b0;
    end else begin
      bin_cnt    <= b_nxt;
      n_gr_cnt   <= g_nxt;
      n_1_gr_cnt <= g1_nxt;
      wrap       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_cnt_dual_p.sv
// Randomised self-checking bench for gray_cnt_dual_p against an arithmetic reference model.
module tb_gray_cnt_dual_p;

  localparam int unsigned N    = 4;
  localparam int unsigned RV   = 6;
  localparam int unsigned MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         ld;
  logic [N-1:0] ld_val;
  logic [N-1:0] n_gr_cnt;
  logic [N-2:0] n_1_gr_cnt;
  logic [N-1:0] bin_cnt;
  logic         tc;
  logic         wrap;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m      = 0;
  int unsigned mw     = 0;
  int unsigned prev_g = 0;
  int unsigned prev_g1 = 0;

  gray_cnt_dual_p #(.N(N), .RST_VAL(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_dn      (up_dn),
    .ld         (ld),
    .ld_val     (ld_val),
    .n_gr_cnt   (n_gr_cnt),
    .n_1_gr_cnt (n_1_gr_cnt),
    .bin_cnt    (bin_cnt),
    .tc         (tc),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  function automatic int unsigned gray(input int unsigned x);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit l, input int unsigned v, input bit e, input bit u);
    mw = 0;
    if (l) m = v;
    else if (e) begin
      if (u) begin
        if (m == MAXV) begin
`ifdef GRAY_CNT_SAT_EN
          m = MAXV;
`else
          m = 0; mw = 1;
`endif
        end else m = m + 1;
      end else begin
        if (m == 0) begin
`ifdef GRAY_CNT_SAT_EN
          m = 0;
`else
          m = MAXV; mw = 1;
`endif
        end else m = m - 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("bin_cnt", bin_cnt, m);
    check("n_gr_cnt", n_gr_cnt, gray(m));
    check("n_1_gr_cnt", n_1_gr_cnt, gray(m % (1 << (N - 1))));
    check("wrap", wrap, mw);
  endtask

  // Drive one cycle of inputs, check tc before the edge and registered outputs after it.
  task automatic step(input bit l, input int unsigned v, input bit e, input bit u);
    bit moved;
    ld = l; ld_val = v[N-1:0]; en = e; up_dn = u;
    #1;
    check("tc", tc, u ? (m == MAXV) : (m == 0));
    prev_g  = n_gr_cnt;
    prev_g1 = n_1_gr_cnt;
    @(posedge clk);
    #1;
    moved = !l && e && (gray(m) != prev_g);
    model_step(l, v, e, u);
    check_outputs();
    if (moved) begin
      check("gray_1bit", $countones(prev_g ^ n_gr_cnt), 1);
      check("gray1_1bit", $countones(prev_g1 ^ n_1_gr_cnt), 1);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; ld = 1'b0; ld_val = '0;
    #12;
    m = RV; mw = 0;
    check_outputs();
    check("rst_gray_const", n_gr_cnt, 5);
    check("rst_gray1_const", n_1_gr_cnt, 5);
    @(negedge clk);
    rst = 1'b1;

    // Free-running up count from 0 across the wrap
    step(1, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 1);

    // Down count through zero
    step(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0);

    // Load beats enable
    step(1, 10, 1, 1);
    check("ld_gray_const", n_gr_cnt, 4'hF);

    // Direction change then hold
    step(1, 3, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Saturation / wrap edges
    step(1, 13, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Asynchronous reset between edges at count 9
    step(1, 9, 0, 1);
    en = 1'b1; up_dn = 1'b1; ld = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m = RV; mw = 0;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(7) == 0), $urandom_range(MAXV), ($urandom_range(3) != 0),
           $urandom_range(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
